// File: rtl/prbs16_checker.sv
// PRBS16 (x^16+x^14+x^13+x^11+1) serial checker: self-syncing, lock tracking, error stats.
// Optional bit counter enabled by defining PRBS16_CHK_BITCNT_EN.
module prbs16_checker #(
    parameter int LOCK_CNT = 32,
    parameter int LOSS_CNT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    typedef enum logic {HUNT, LOCK} state_t;

    localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

    state_t      state;
    logic [15:0] sr;
    logic [4:0]  fill_cnt;
    logic [7:0]  good_cnt;
    logic [7:0]  bad_cnt;
    logic        pred;
    logic        miss;
    logic        count_err;

    assign pred      = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
    assign miss      = in_bit ^ pred;
    assign count_err = in_valid && (state == LOCK) && miss;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        sr <= {sr[14:0], in_bit};
                        if (fill_cnt != 5'd16) begin
                            fill_cnt <= fill_cnt + 5'd1;
                        end else if (!miss && sr != '0) begin
                            good_cnt <= good_cnt + 8'd1;
                            if (good_cnt + 8'd1 == LOCK_N) begin
                                state   <= LOCK;
                                locked  <= 1'b1;
                                bad_cnt <= '0;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        // Free-run on the prediction so line errors never corrupt sr
                        sr <= {sr[14:0], pred};
                        if (miss) begin
                            err_pulse <= 1'b1;
                            bad_cnt   <= bad_cnt + 8'd1;
                            if (bad_cnt + 8'd1 == LOSS_N) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                fill_cnt <= '0;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (count_err && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end

`ifdef PRBS16_CHK_BITCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_count <= '0;
        end else if (clear) begin
            bit_count <= '0;
        end else if (in_valid && state == LOCK) begin
            bit_count <= bit_count + 32'd1;
        end
    end
`else
    assign bit_count = '0;
`endif

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial receive-side checker for the 16-bit Fibonacci LFSR pattern generator: taps 15, 13, 12 and 10, shifting left with feedback into bit 0. It consumes the generator's bit stream one bit per valid cycle and self-synchronises to it. Once locked, it predicts every subsequent bit and counts mismatches. It sits at the far end of the link or loopback path under test and reports lock status and bit-error statistics to control logic.

## Interface
- `LOCK_CNT`, default 32: consecutive correct predictions required to declare lock (1..255).
- `LOSS_CNT`, default 8: consecutive mismatches while locked that force loss of lock (1..255).

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `in_bit` is a new stream bit this cycle
- `in_bit`  in  1  received stream bit
- `clear`  in  1  synchronous clear of statistics counters
- `locked`  out  1  checker is in LOCKED state
- `err_pulse`  out  1  one-cycle strobe: last valid bit mismatched while locked
- `err_count`  out  16  saturating count of mismatches while locked
- `bit_count`  out  32  valid bits checked while locked (see Configuration)

## Operation
- Stream definition: b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11]. This equals the generator's feedback bit each cycle.
- Internal 16-bit shadow `sr`, with sr[0] the newest bit. Predicted bit p = sr[15]^sr[13]^sr[12]^sr[10].
- When `in_valid`=0, all state holds and `err_pulse`=0.

HUNT state (the reset state):
- Every valid bit shifts in: sr <= {sr[14:0], in_bit}.
- `fill_cnt` (0..16) increments per valid bit and saturates at 16. While it is below 16, no comparison is made.
- Once `fill_cnt`=16, each valid bit is compared with p:
  - Match with sr != 0 → `good_cnt`++.
  - Mismatch, or sr == 0 → `good_cnt` <= 0. An all-zero stream never locks.
- When `good_cnt` reaches LOCK_CNT → LOCKED, and `bad_cnt` <= 0.
- No errors are counted in HUNT.

LOCKED state:
- The shadow free-runs on its own prediction: sr <= {sr[14:0], p}. A received error therefore does not propagate.
- Mismatch (in_bit != p):
  - `err_pulse` fires.
  - `err_count`++, saturating at 16'hFFFF.
  - `bad_cnt`++.
- Match → `bad_cnt` <= 0.
- When `bad_cnt` reaches LOSS_CNT → HUNT, with `fill_cnt`, `good_cnt` and `bad_cnt` all <= 0. The mismatch that triggers the transition is still counted.

`clear`:
- Zeroes `err_count` and `bit_count`.
- Has priority over a same-cycle increment: the result is 0.
- Does not affect state, sr or lock.

## Timing
- All outputs are registered. Reset values: `locked`=0, `err_pulse`=0, `err_count`=0, `bit_count`=0, internal state HUNT with all counters and sr at 0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).
- Lock latency: `locked` rises the cycle after the (16+LOCK_CNT)-th valid bit of an error-free stream.
- `err_pulse` and `err_count` update the cycle after the offending valid bit.
- `locked` falls the cycle after the LOSS_CNT-th consecutive mismatch.
- Throughput: one bit per cycle. `in_valid` may be asserted continuously or with arbitrary gaps.

## Configuration
- `PRBS16_CHK_BITCNT_EN` defined:
  - `bit_count` increments on every valid bit while LOCKED, including the loss-triggering bit.
  - 32-bit, wraps to 0 after 32'hFFFF_FFFF.
  - Cleared by `clear`.
- Undefined: no counter logic; `bit_count` is tied to 0.

## Test plan
- Generator seeded 16'hACE1, continuous `in_valid`, defaults → `locked`=0 through bit 47, `locked`=1 the cycle after bit 48; `err_count` stays 0 over 10,000 further bits, and `bit_count`=10,000 with the macro defined.
- Locked, invert one bit → exactly one `err_pulse`, `err_count`=1, `locked` stays 1, and the next 100 clean bits add no errors.
- Locked, invert 8 consecutive bits → `err_count`=8, `locked`=0 the cycle after the 8th. Clean stream continues → relock after 48 more bits, and `err_count` holds at 8 during HUNT.
- 500 valid zero bits from reset → `locked` never asserts and `err_count`=0.
- Locked stream with random `in_valid` gaps (about 50% duty) → no false errors; `clear` asserted on a mismatch cycle → `err_count`=0 the next cycle.
- `reset` pulsed mid-lock between clock edges → outputs go to 0 without waiting for a clock edge, and relock takes 48 bits.
